// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and
// the width of the beat latency counter.
package mem_if_pkg;

  // Wide enough for any latency in 0..15.
  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    R_WAIT,
    R_RDY,
    R_ACK,
    W_WAIT,
    W_RDY,
    W_ACK
  } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Byte-wide storage for the responder: one write port, one registered
// read port and one combinational peek port.
module mem_responder_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_zero_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  input  logic [AW-1:0] peek_addr_i,
  output logic [7:0]    peek_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto plain RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read register holds its value between beats; out-of-range beats read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rd_data_q <= 8'h00;
    else if (rd_en_i) rd_data_q <= rd_zero_i ? 8'h00 : mem_q[rd_addr_i];
  end

  assign rd_data_o   = rd_data_q;
  assign peek_data_o = mem_q[peek_addr_i];

endmodule

// File: rtl/mem_responder.sv
// Beat-oriented memory responder: serves read and write bursts one byte per
// handshake with a fixed latency between address capture and the ready pulse.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int  DEPTH   = 128,
  parameter int  LATENCY = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read_enable,
  input  logic [63:0]   read_addr,
  input  logic          finish_read,
  output logic          read_ready,
  output logic [7:0]    read_data,
  input  logic          write_enable,
  input  logic [63:0]   write_addr,
  input  logic [7:0]    write_data,
  input  logic          finish_write,
  output logic          write_ready,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [AW-1:0] peek_addr,
  output logic [7:0]    peek_data,
  output logic [31:0]   read_beats,
  output logic [31:0]   write_beats,
  output logic          addr_err
);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               oor_q, oor_d;
  logic               read_ready_q, write_ready_q;
  logic [31:0]        read_beats_q, write_beats_q;
  logic               addr_err_q;
  logic               cap_rd, cap_wr, rd_go, wr_go;

  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    cap_rd  = 1'b0;
    cap_wr  = 1'b0;
    rd_go   = 1'b0;
    wr_go   = 1'b0;

    case (state_q)
      IDLE: begin
        if (read_enable)       cap_rd = 1'b1;
        else if (write_enable) cap_wr = 1'b1;
      end
      R_WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (!read_enable) state_d = IDLE;
        else if (cnt_q == LAT_W'(1)) begin
          state_d = R_RDY;
          rd_go   = 1'b1;
        end
      end
      R_RDY: state_d = R_ACK;
      R_ACK: begin
        if (finish_read)       cap_rd  = 1'b1;
        else if (!read_enable) state_d = IDLE;
      end
      W_WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (!write_enable) state_d = IDLE;
        else if (cnt_q == LAT_W'(1)) begin
          state_d = W_RDY;
          wr_go   = 1'b1;
        end
      end
      W_RDY: state_d = W_ACK;
      W_ACK: begin
        if (finish_write)       cap_wr  = 1'b1;
        else if (!write_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only the low index bits are kept; the range flag covers the rest of the address.
    if (cap_rd) begin
      addr_d = read_addr[AW-1:0];
      oor_d  = (read_addr >= 64'(DEPTH));
      cnt_d  = LAT_W'(LATENCY);
      rd_go  = (LATENCY == 0);
      state_d = (LATENCY == 0) ? R_RDY : R_WAIT;
    end else if (cap_wr) begin
      addr_d = write_addr[AW-1:0];
      oor_d  = (write_addr >= 64'(DEPTH));
      cnt_d  = LAT_W'(LATENCY);
      wr_go  = (LATENCY == 0);
      state_d = (LATENCY == 0) ? W_RDY : W_WAIT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      oor_q         <= 1'b0;
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
      read_beats_q  <= '0;
      write_beats_q <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      oor_q         <= oor_d;
      read_ready_q  <= rd_go;
      write_ready_q <= wr_go;
      if (rd_go) read_beats_q  <= read_beats_q + 32'd1;
      if (wr_go) write_beats_q <= write_beats_q + 32'd1;
      if ((rd_go || wr_go) && oor_d) addr_err_q <= 1'b1;
    end
  end

  // The committing write and the backdoor load are mutually exclusive by state.
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;

  assign ram_we    = ((state_q == W_RDY) && !oor_q) || (load_en && (state_q == IDLE));
  assign ram_waddr = (state_q == W_RDY) ? addr_q     : load_addr;
  assign ram_wdata = (state_q == W_RDY) ? write_data : load_data;

  mem_responder_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (ram_we),
    .wr_addr_i   (ram_waddr),
    .wr_data_i   (ram_wdata),
    .rd_en_i     (rd_go),
    .rd_zero_i   (oor_d),
    .rd_addr_i   (addr_d),
    .rd_data_o   (read_data),
    .peek_addr_i (peek_addr),
    .peek_data_o (peek_data)
  );

  assign read_ready  = read_ready_q;
  assign write_ready = write_ready_q;
  assign read_beats  = read_beats_q;
  assign write_beats = write_beats_q;
  assign addr_err    = addr_err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 128, byte-wide storage entries; index width AW = clog2(DEPTH).
REQ-002 Parameter LATENCY, default 2, idle cycles between request capture and ready beat; legal range 0..15.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 read_enable  in  1  initiator read request, held high for the whole burst.
REQ-006 read_addr  in  64  byte address of current read beat.
REQ-007 finish_read  in  1  one-cycle pulse: beat consumed, read_addr already advanced, next beat wanted.
REQ-008 read_ready  out  1  one-cycle pulse: read_data valid.
REQ-009 read_data  out  8  read beat data, registered.
REQ-010 write_enable  in  1  initiator write request, held high for the whole burst.
REQ-011 write_addr  in  64  byte address of current write beat.
REQ-012 write_data  in  8  write beat data.
REQ-013 finish_write  in  1  one-cycle pulse: beat accepted, write_addr/write_data already advanced.
REQ-014 write_ready  out  1  one-cycle pulse: current write beat committed.
REQ-015 load_en / load_addr[AW-1:0] / load_data[7:0]  in  backdoor preload, one byte per cycle, only honoured in IDLE.
REQ-016 peek_addr[AW-1:0]  in, peek_data[7:0]  out  combinational backdoor read of storage.
REQ-017 read_beats / write_beats  out  32  beats served since reset.
REQ-018 addr_err  out  1  sticky, set on any beat with address >= DEPTH.

Function
REQ-019 FSM states SHALL be IDLE, R_WAIT, R_RDY, R_ACK, W_WAIT, W_RDY, W_ACK.
REQ-020 IDLE: read_enable high -> capture read_addr, load latency counter with LATENCY, go R_WAIT (R_RDY if LATENCY=0); else write_enable high -> same with write_addr into W_WAIT/W_RDY; read has priority when both high.
REQ-021 R_WAIT/W_WAIT SHALL decrement the counter each cycle and move to R_RDY/W_RDY when it reaches 1 before decrement, giving ready exactly LATENCY+1 cycles after capture.
REQ-022 R_RDY: read_ready=1 for exactly one cycle, read_data=mem[captured addr mod DEPTH] (0 if out of range), read_beats+1, then R_ACK.
REQ-023 R_ACK: finish_read=1 -> capture read_addr, reload counter, go R_WAIT/R_RDY; else read_enable=0 -> IDLE; else hold.
REQ-024 W_RDY: mem[captured addr] <= write_data sampled that cycle (suppressed if out of range), write_ready=1 one cycle, write_beats+1, then W_ACK.
REQ-025 W_ACK: finish_write=1 -> capture write_addr, reload counter, re-enter W_WAIT/W_RDY; else write_enable=0 -> IDLE.
REQ-026 Enable dropping in any WAIT state SHALL abort the beat: no ready, no storage write, return to IDLE.
REQ-027 read_ready and write_ready SHALL never be high in the same cycle, nor high in two consecutive cycles.
REQ-028 read_data SHALL hold its last value outside R_RDY.
REQ-029 Counters SHALL wrap at 2^32; addr_err cleared only by reset.
REQ-030 load_en outside IDLE SHALL be ignored; load and W_RDY never coincide.

Reset
REQ-031 On reset: state IDLE, read_ready=0, write_ready=0, read_data=0, read_beats=0, write_beats=0, addr_err=0, counter 0.
REQ-032 Storage SHALL NOT be reset; reset mid-burst SHALL discard the pending beat without a storage write.

Structure
REQ-033 Shared package mem_if_pkg SHALL hold the state enum and LATENCY width constant.
REQ-034 Storage SHALL be one sub-module mem_responder_ram: one write port (W_RDY or load), one sync read port, one async peek port.

Verification
REQ-035 Preload mem[0..3]=11,22,33,44; 4-beat read, addr 0 stride 1, LATENCY=2 -> read_ready 3 cycles after each capture, data 11,22,33,44, read_beats=4.
REQ-036 4-beat write at addr 8, data A0..A3 -> four write_ready pulses, peek 8..11 = A0..A3, write_beats=4.
REQ-037 read_enable and write_enable raised together -> read burst served first, no write_ready until IDLE re-entered.
REQ-038 Read at addr 200 with DEPTH=128 -> read_data=0, addr_err=1 and stays 1 after burst.
REQ-039 Reset asserted in W_WAIT -> all outputs zero immediately, target byte unchanged.
REQ-040 LATENCY=0, 2-beat read -> read_ready the cycle after capture and the cycle after finish_read.
